muldiv_sequencer: RTL and testbench

- Sequences the shared multiplier and divisor units on behalf of the main control FSM.
- Accepts one mult/div request, pulses the selected unit's start, and waits for its fim handshake.
- On completion, selects and writes HI/LO. On divide-by-zero or timeout, raises a one-cycle exception pulse.
- Sits between the main control unit and the multiplier, divisor and HI/LO register/mux pair.

---
 rtl/muldiv_sequencer.sv | 95 +++++++++
 tb/tb_muldiv_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Sequences the shared multiplier/divisor: one request, one start pulse, then waits for
// the unit's fim handshake to write HI/LO, or raises a divide-by-zero/timeout exception.
module muldiv_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 40,
    parameter int unsigned CNT_W          = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req,
    input  logic             op,
    input  logic             mult_fim,
    input  logic             div_fim,
    input  logic             div_by_zero,
    output logic             busy,
    output logic             mult_start,
    output logic             div_start,
    output logic             hi_sel,
    output logic             lo_sel,
    output logic             hi_write,
    output logic             lo_write,
    output logic             done,
    output logic             exc_div_zero,
    output logic             exc_timeout,
    output logic [CNT_W-1:0] last_cycles
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] WRITE  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;
    localparam logic [2:0] ERR_DZ = 3'd5;
    localparam logic [2:0] ERR_TO = 3'd6;

    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state;
    logic [2:0]       stateNext;
    logic             opQ;
    logic [CNT_W-1:0] counter;
    logic             selFim;

    assign selFim = opQ ? div_fim : mult_fim;

    // Divide-by-zero outranks fim, and fim on the final allowed cycle outranks timeout.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:   if (req) stateNext = START;
            START:  stateNext = WAIT;
            WAIT: begin
                if (opQ && div_by_zero)     stateNext = ERR_DZ;
                else if (selFim)            stateNext = WRITE;
                else if (counter == LAST_WAIT) stateNext = ERR_TO;
            end
            WRITE:  stateNext = DONE;
            DONE:   stateNext = IDLE;
            ERR_DZ: stateNext = IDLE;
            ERR_TO: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            opQ         <= 1'b0;
            counter     <= '0;
            last_cycles <= '0;
        end else begin
            state <= stateNext;
            if (state == IDLE && req) opQ <= op;
            if (state == START) begin
                counter <= '0;
            end else if (state == WAIT && stateNext == WAIT) begin
                counter <= counter + CNT_W'(1);
            end
            if (state == WAIT && stateNext == WRITE) last_cycles <= counter + CNT_W'(1);
        end
    end

    always_comb begin
        busy         = (state != IDLE);
        mult_start   = (state == START) && !opQ;
        div_start    = (state == START) && opQ;
        hi_sel       = busy && opQ;
        lo_sel       = busy && opQ;
        hi_write     = (state == WRITE);
        lo_write     = (state == WRITE);
        done         = (state == DONE);
        exc_div_zero = (state == ERR_DZ);
        exc_timeout  = (state == ERR_TO);
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: table-driven operations with per-cycle output
// checks, plus a scoreboard of completion kinds/last_cycles popped on each result pulse.
module tb_muldiv_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       req;
    logic       op;
    logic       mult_fim;
    logic       div_fim;
    logic       div_by_zero;
    logic       busy;
    logic       mult_start;
    logic       div_start;
    logic       hi_sel;
    logic       lo_sel;
    logic       hi_write;
    logic       lo_write;
    logic       done;
    logic       exc_div_zero;
    logic       exc_timeout;
    logic [5:0] last_cycles;

    muldiv_sequencer #(
        .TIMEOUT_CYCLES(40),
        .CNT_W(6)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req(req),
        .op(op),
        .mult_fim(mult_fim),
        .div_fim(div_fim),
        .div_by_zero(div_by_zero),
        .busy(busy),
        .mult_start(mult_start),
        .div_start(div_start),
        .hi_sel(hi_sel),
        .lo_sel(lo_sel),
        .hi_write(hi_write),
        .lo_write(lo_write),
        .done(done),
        .exc_div_zero(exc_div_zero),
        .exc_timeout(exc_timeout),
        .last_cycles(last_cycles)
    );

    always #5 clock = ~clock;

    // kind: 0 = done, 1 = divide-by-zero, 2 = timeout; endAt = WAIT cycle that ends the wait
    typedef struct {
        logic       op;
        int         fimAt;
        int         dzAt;
        logic       stray;
        int         kind;
        int         endAt;
        logic [5:0] lastExp;
    } vec_t;

    typedef struct {
        int         kind;
        logic [5:0] last;
    } sb_t;

    sb_t        sb[$];
    vec_t       tbl[10];
    int         passCnt  = 0;
    int         totalCnt = 0;
    logic [5:0] prevLast = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] outVec();
        return {busy, mult_start, div_start, hi_sel, lo_sel, hi_write, lo_write,
                done, exc_div_zero, exc_timeout, last_cycles};
    endfunction

    function automatic logic [15:0] mkVec(input logic b, input logic ms, input logic ds,
                                          input logic sel, input logic wr, input logic dn,
                                          input logic edz, input logic eto, input logic [5:0] lst);
        return {b, ms, ds, sel, sel, wr, wr, dn, edz, eto, lst};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic runOp(input vec_t v, input string tag);
        int   lastCyc;
        int   cyc;
        logic selF;
        logic b;
        logic wr;
        logic dn;
        logic edz;
        logic eto;
        logic [5:0] lst;
        req = 1'b1;
        op  = v.op;
        sb.push_back('{v.kind, v.lastExp});
        tick();
        req = 1'b0;
        op  = ~v.op;
        chk($sformatf("%s_start", tag), 32'(outVec()),
            32'(mkVec(1'b1, !v.op, v.op, v.op, 1'b0, 1'b0, 1'b0, 1'b0, prevLast)));
        lastCyc = (v.kind == 0) ? v.endAt + 4 : v.endAt + 3;
        for (int j = 1; j <= lastCyc - 1; j++) begin
            tick();
            cyc  = j + 1;
            selF = (v.fimAt > 0) && (j >= v.fimAt) && (j <= v.fimAt + 1);
            mult_fim    = v.op ? v.stray : selF;
            div_fim     = v.op ? selF : v.stray;
            div_by_zero = (v.dzAt > 0) && (j == v.dzAt);
            b   = (v.kind == 0) ? (cyc <= v.endAt + 3) : (cyc <= v.endAt + 2);
            wr  = (v.kind == 0) && (cyc == v.endAt + 2);
            dn  = (v.kind == 0) && (cyc == v.endAt + 3);
            edz = (v.kind == 1) && (cyc == v.endAt + 2);
            eto = (v.kind == 2) && (cyc == v.endAt + 2);
            lst = (cyc <= v.endAt + 1) ? prevLast : v.lastExp;
            chk($sformatf("%s_cyc%0d", tag, cyc), 32'(outVec()),
                32'(mkVec(b, 1'b0, 1'b0, b & v.op, wr, dn, edz, eto, lst)));
        end
        mult_fim    = 1'b0;
        div_fim     = 1'b0;
        div_by_zero = 1'b0;
        prevLast    = v.lastExp;
    endtask

    // Scoreboard side: every result pulse must match the oldest outstanding operation.
    always @(negedge clock) begin
        int  got;
        sb_t e;
        chk("start_exclusive", 32'(mult_start & div_start), 32'd0);
        if (done || exc_div_zero || exc_timeout) begin
            got = (32'(done) + 32'(exc_div_zero) + 32'(exc_timeout) > 1) ? 3 :
                  done ? 0 : exc_div_zero ? 1 : 2;
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_kind", 32'(got), 32'(e.kind));
                chk("sb_last", 32'(last_cycles), 32'(e.last));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1);
    end

    initial begin
        int   p;
        logic opAcc;
        logic [5:0] lst;

        tbl[0] = '{1'b0, 33, 0, 1'b0, 0, 33, 6'd33};  // mult, normal
        tbl[1] = '{1'b1,  0, 2, 1'b0, 1,  2, 6'd33};  // div by zero in WAIT 2
        tbl[2] = '{1'b1,  3, 3, 1'b0, 1,  3, 6'd33};  // dz and div_fim together
        tbl[3] = '{1'b0,  0, 0, 1'b1, 2, 40, 6'd33};  // stray div_fim, mult withheld
        tbl[4] = '{1'b0, 40, 0, 1'b0, 0, 40, 6'd40};  // fim on final allowed cycle
        tbl[5] = '{1'b0, 41, 0, 1'b0, 2, 40, 6'd40};  // fim one cycle too late
        tbl[6] = '{1'b1,  1, 0, 1'b0, 0,  1, 6'd1};   // div, fim in first WAIT
        tbl[7] = '{1'b0,  5, 2, 1'b0, 0,  5, 6'd5};   // dz ignored for mult
        tbl[8] = '{1'b1,  4, 0, 1'b1, 0,  4, 6'd4};   // stray mult_fim ignored
        tbl[9] = '{1'b0,  2, 0, 1'b1, 0,  2, 6'd2};   // stray div_fim ignored

        reset = 1'b1; req = 1'b0; op = 1'b0;
        mult_fim = 1'b0; div_fim = 1'b0; div_by_zero = 1'b0;
        tick();
        tick();
        chk("reset_state", 32'(outVec()), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_after_reset", 32'(outVec()), 32'd0);

        for (int i = 0; i < 10; i++) runOp(tbl[i], $sformatf("vec%0d", i));

        // Abort mid-WAIT with an asynchronous reset.
        req = 1'b1;
        op  = 1'b0;
        tick();
        req = 1'b0;
        chk("abort_start", 32'(outVec()),
            32'(mkVec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, prevLast)));
        tick();
        tick();
        #3;
        reset = 1'b1;
        #1;
        chk("reset_async", 32'(outVec()), 32'd0);
        tick();
        chk("reset_hold", 32'(outVec()), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_after_abort", 32'(outVec()), 32'd0);
        prevLast = '0;
        runOp('{1'b1, 3, 0, 1'b0, 0, 3, 6'd3}, "restart");

        // req held high, op toggling every cycle, both units answering immediately.
        req = 1'b1;
        op  = 1'b0;
        mult_fim = 1'b1;
        div_fim  = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            p     = (c - 1) % 5;
            opAcc = ((c - 1 - p) % 2) != 0;
            lst   = (p >= 2 || c > 5) ? 6'd1 : prevLast;
            if (p == 0) sb.push_back('{0, 6'd1});
            chk($sformatf("b2b_cyc%0d", c), 32'(outVec()),
                32'(mkVec(p < 4, (p == 0) && !opAcc, (p == 0) && opAcc, (p < 4) && opAcc,
                          p == 2, p == 3, 1'b0, 1'b0, lst)));
            op = (c % 2) != 0;
            if (c == 20) req = 1'b0;
        end
        mult_fim = 1'b0;
        div_fim  = 1'b0;
        prevLast = 6'd1;
        tick();
        chk("final_idle", 32'(outVec()),
            32'(mkVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, prevLast)));
        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
